vending_machine_multi: RTL and testbench

- Parametrised successor to the single-product vending FSM.
- Sells NUM_PROD products with per-product prices and per-product stock counters.
- Accepts 5/10/25-unit coins; supports cancel/refund.
- Returns change as a serial train of one-coin-per-cycle pulses (greedy 25/10/5), so it can drive a physical coin hopper directly.

---
 rtl/vending_machine_multi_if.sv | 37 +++
 rtl/vending_machine_multi.sv | 178 +++++++++++++++++
 tb/tb_vending_machine_multi.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/vending_machine_multi_if.sv
// Customer-facing coin/command inputs and vend/change/status outputs of the
// multi-product vending machine.
interface vending_machine_multi_if #(
  parameter int unsigned NUM_PROD = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned W        = 8
);
  logic                coin5;
  logic                coin10;
  logic                coin25;
  logic [SEL_W-1:0]    sel;
  logic                buy;
  logic                cancel;
  logic                restock;
  logic                dispense;
  logic [SEL_W-1:0]    disp_id;
  logic                chg25;
  logic                chg10;
  logic                chg5;
  logic                coin_reject;
  logic                deny;
  logic [W-1:0]        credit;
  logic                busy;
  logic [NUM_PROD-1:0] sold_out;

  modport master (
    output coin5, coin10, coin25, sel, buy, cancel, restock,
    input  dispense, disp_id, chg25, chg10, chg5, coin_reject, deny,
           credit, busy, sold_out
  );

  modport slave (
    input  coin5, coin10, coin25, sel, buy, cancel, restock,
    output dispense, disp_id, chg25, chg10, chg5, coin_reject, deny,
           credit, busy, sold_out
  );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-product vending FSM with per-product price/stock, credit ceiling and
// serial greedy change output (one coin pulse per cycle).
module vending_machine_multi #(
  parameter int unsigned         NUM_PROD   = 4,
  parameter int unsigned         SEL_W      = 2,
  parameter int unsigned         W          = 8,
  parameter logic [NUM_PROD*W-1:0] PRICES   = {8'd50, 8'd40, 8'd30, 8'd25},
  parameter int unsigned         STOCK_W    = 4,
  parameter int unsigned         STOCK_INIT = 4,
  parameter int unsigned         MAX_CREDIT = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vending_machine_multi_if.slave vm
);

  localparam int unsigned CW = W + 1;

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_e;

  state_e              r_state, w_state_nxt;
  logic [W-1:0]        r_credit, w_credit_nxt;
  logic [STOCK_W-1:0]  r_stock     [NUM_PROD];
  logic [STOCK_W-1:0]  w_stock_nxt [NUM_PROD];
  logic [SEL_W-1:0]    r_vend_id, w_vend_id_nxt;
  logic                r_dispense, w_dispense_nxt;
  logic [SEL_W-1:0]    r_disp_id, w_disp_id_nxt;
  logic                r_chg25, w_chg25_nxt;
  logic                r_chg10, w_chg10_nxt;
  logic                r_chg5, w_chg5_nxt;
  logic                r_coin_reject, w_coin_reject_nxt;
  logic                r_deny, w_deny_nxt;
  logic                r_busy;
  logic [NUM_PROD-1:0] r_sold_out, w_sold_out_nxt;

  logic [W-1:0]        w_price;
  logic [STOCK_W-1:0]  w_sel_stock;
  logic                w_sel_valid;
  logic                w_coin_any;
  logic [CW-1:0]       w_coin_sum;
  logic                w_coin_over;
  logic                w_cmd_taken;

  // Price/stock lookup for the selected product; out-of-range selects stay invalid
  always_comb begin
    w_price     = '0;
    w_sel_stock = '0;
    w_sel_valid = 1'b0;
    for (int i = 0; i < int'(NUM_PROD); i++) begin
      if (vm.sel == SEL_W'(i)) begin
        w_price     = PRICES[i*W +: W];
        w_sel_stock = r_stock[i];
        w_sel_valid = 1'b1;
      end
    end
  end

  assign w_coin_any  = vm.coin5 | vm.coin10 | vm.coin25;
  assign w_coin_sum  = (vm.coin5  ? CW'(5)  : CW'(0))
                     + (vm.coin10 ? CW'(10) : CW'(0))
                     + (vm.coin25 ? CW'(25) : CW'(0));
  assign w_coin_over = (CW'(r_credit) + w_coin_sum) > CW'(MAX_CREDIT);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_credit_nxt      = r_credit;
    w_stock_nxt       = r_stock;
    w_vend_id_nxt     = r_vend_id;
    w_dispense_nxt    = 1'b0;
    w_disp_id_nxt     = '0;
    w_chg25_nxt       = 1'b0;
    w_chg10_nxt       = 1'b0;
    w_chg5_nxt        = 1'b0;
    w_coin_reject_nxt = 1'b0;
    w_deny_nxt        = 1'b0;
    w_cmd_taken       = 1'b0;
    w_sold_out_nxt    = '0;

    case (r_state)
      IDLE, CREDIT: begin
        if (vm.cancel && (r_credit != '0)) begin
          w_state_nxt = CHANGE;
          w_cmd_taken = 1'b1;
        end else if (vm.restock) begin
          for (int i = 0; i < int'(NUM_PROD); i++) w_stock_nxt[i] = STOCK_W'(STOCK_INIT);
        end else if (vm.buy) begin
          if (!w_sel_valid || (w_sel_stock == '0) || (r_credit < w_price)) begin
            w_deny_nxt = 1'b1;
          end else begin
            w_state_nxt   = VEND;
            w_credit_nxt  = r_credit - w_price;
            w_vend_id_nxt = vm.sel;
            w_cmd_taken   = 1'b1;
            for (int i = 0; i < int'(NUM_PROD); i++)
              if (vm.sel == SEL_W'(i)) w_stock_nxt[i] = r_stock[i] - STOCK_W'(1);
          end
        end
        // Coins ride along only when no buy/cancel was taken and the ceiling holds
        if (w_coin_any) begin
          if (w_cmd_taken || w_coin_over) begin
            w_coin_reject_nxt = 1'b1;
          end else begin
            w_credit_nxt = W'(CW'(r_credit) + w_coin_sum);
            w_state_nxt  = CREDIT;
          end
        end
      end
      VEND: begin
        w_dispense_nxt    = 1'b1;
        w_disp_id_nxt     = r_vend_id;
        w_coin_reject_nxt = w_coin_any;
        w_state_nxt       = (r_credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        w_coin_reject_nxt = w_coin_any;
        if (r_credit >= W'(25)) begin
          w_chg25_nxt  = 1'b1;
          w_credit_nxt = r_credit - W'(25);
        end else if (r_credit >= W'(10)) begin
          w_chg10_nxt  = 1'b1;
          w_credit_nxt = r_credit - W'(10);
        end else if (r_credit != '0) begin
          w_chg5_nxt   = 1'b1;
          w_credit_nxt = r_credit - W'(5);
        end
        if (w_credit_nxt == '0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    for (int i = 0; i < int'(NUM_PROD); i++) w_sold_out_nxt[i] = (w_stock_nxt[i] == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_credit      <= '0;
      for (int i = 0; i < int'(NUM_PROD); i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
      r_vend_id     <= '0;
      r_dispense    <= 1'b0;
      r_disp_id     <= '0;
      r_chg25       <= 1'b0;
      r_chg10       <= 1'b0;
      r_chg5        <= 1'b0;
      r_coin_reject <= 1'b0;
      r_deny        <= 1'b0;
      r_busy        <= 1'b0;
      r_sold_out    <= (STOCK_INIT == 0) ? '1 : '0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_stock       <= w_stock_nxt;
      r_vend_id     <= w_vend_id_nxt;
      r_dispense    <= w_dispense_nxt;
      r_disp_id     <= w_disp_id_nxt;
      r_chg25       <= w_chg25_nxt;
      r_chg10       <= w_chg10_nxt;
      r_chg5        <= w_chg5_nxt;
      r_coin_reject <= w_coin_reject_nxt;
      r_deny        <= w_deny_nxt;
      r_busy        <= (w_state_nxt == VEND) || (w_state_nxt == CHANGE);
      r_sold_out    <= w_sold_out_nxt;
    end
  end

  assign vm.dispense    = r_dispense;
  assign vm.disp_id     = r_disp_id;
  assign vm.chg25       = r_chg25;
  assign vm.chg10       = r_chg10;
  assign vm.chg5        = r_chg5;
  assign vm.coin_reject = r_coin_reject;
  assign vm.deny        = r_deny;
  assign vm.credit      = r_credit;
  assign vm.busy        = r_busy;
  assign vm.sold_out    = r_sold_out;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi; prices are 25/30/40/50 for products 0..3.
module tb_vending_machine_multi;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  vending_machine_multi_if vm_if ();

  vending_machine_multi dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vm    (vm_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, then clear them
  task automatic step(input logic c5, input logic c10, input logic c25,
                      input logic b, input logic cn, input logic rs,
                      input logic [1:0] s);
    vm_if.coin5   = c5;
    vm_if.coin10  = c10;
    vm_if.coin25  = c25;
    vm_if.buy     = b;
    vm_if.cancel  = cn;
    vm_if.restock = rs;
    vm_if.sel     = s;
    @(posedge clk);
    #1;
    vm_if.coin5   = 1'b0;
    vm_if.coin10  = 1'b0;
    vm_if.coin25  = 1'b0;
    vm_if.buy     = 1'b0;
    vm_if.cancel  = 1'b0;
    vm_if.restock = 1'b0;
    vm_if.sel     = 2'd0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 2'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    vm_if.coin5 = 1'b0; vm_if.coin10 = 1'b0; vm_if.coin25 = 1'b0;
    vm_if.buy = 1'b0; vm_if.cancel = 1'b0; vm_if.restock = 1'b0; vm_if.sel = 2'd0;
    idle();
    idle();
    rst_n = 1'b1;
    check("rst_credit",   32'(vm_if.credit),   0);
    check("rst_busy",     32'(vm_if.busy),     0);
    check("rst_sold_out", 32'(vm_if.sold_out), 0);
    check("rst_outs", 32'({vm_if.dispense, vm_if.chg25, vm_if.chg10, vm_if.chg5,
                           vm_if.coin_reject, vm_if.deny}), 0);

    // 60 credit, buy product 1 (30) -> dispense, change 25 + 5
    step(0, 0, 1, 0, 0, 0, 2'd0);
    step(0, 0, 1, 0, 0, 0, 2'd0);
    step(0, 1, 0, 0, 0, 0, 2'd0);
    check("t1_credit60", 32'(vm_if.credit), 60);
    step(0, 0, 0, 1, 0, 0, 2'd1);
    check("t1_vend_busy",   32'(vm_if.busy),   1);
    check("t1_vend_credit", 32'(vm_if.credit), 30);
    idle();
    check("t1_dispense", 32'(vm_if.dispense), 1);
    check("t1_disp_id",  32'(vm_if.disp_id),  1);
    idle();
    check("t1_chg25",    32'(vm_if.chg25),  1);
    check("t1_credit5",  32'(vm_if.credit), 5);
    idle();
    check("t1_chg5",     32'(vm_if.chg5),   1);
    check("t1_credit0",  32'(vm_if.credit), 0);
    check("t1_idle",     32'(vm_if.busy),   0);
    idle();
    check("t1_quiet", 32'({vm_if.chg25, vm_if.chg10, vm_if.chg5}), 0);

    // 25 credit, product 2 costs 40 -> deny; cancel returns one 25
    step(0, 0, 1, 0, 0, 0, 2'd0);
    step(0, 0, 0, 1, 0, 0, 2'd2);
    check("t2_deny",   32'(vm_if.deny),   1);
    check("t2_credit", 32'(vm_if.credit), 25);
    step(0, 0, 0, 0, 1, 0, 2'd0);
    check("t2_cancel_busy", 32'(vm_if.busy), 1);
    idle();
    check("t2_chg25",   32'(vm_if.chg25),  1);
    check("t2_credit0", 32'(vm_if.credit), 0);
    idle();
    check("t2_quiet", 32'({vm_if.chg25, vm_if.chg10, vm_if.chg5, vm_if.busy}), 0);

    // Exhaust product 0 (price 25), then restock
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 0, 0, 2'd0);
      step(0, 0, 0, 1, 0, 0, 2'd0);
      if (k < 4) begin
        check("t3_deny0", 32'(vm_if.deny), 0);
        idle();
        check("t3_dispense", 32'(vm_if.dispense), 1);
      end else begin
        check("t3_deny", 32'(vm_if.deny), 1);
      end
    end
    check("t3_sold_out", 32'(vm_if.sold_out), 32'h1);
    check("t3_credit",   32'(vm_if.credit),   25);
    step(0, 0, 0, 0, 0, 1, 2'd0);
    check("t3_restock", 32'(vm_if.sold_out), 0);
    step(0, 0, 0, 0, 1, 0, 2'd0);
    idle();
    check("t3_refund", 32'(vm_if.chg25), 1);

    // Credit ceiling at 200
    for (int k = 0; k < 7; k++) step(0, 0, 1, 0, 0, 0, 2'd0);
    step(0, 1, 0, 0, 0, 0, 2'd0);
    step(0, 1, 0, 0, 0, 0, 2'd0);
    check("t4_credit195", 32'(vm_if.credit), 195);
    step(1, 1, 0, 0, 0, 0, 2'd0);
    check("t4_reject",    32'(vm_if.coin_reject), 1);
    check("t4_hold195",   32'(vm_if.credit),      195);
    step(1, 0, 0, 0, 0, 0, 2'd0);
    check("t4_noreject",  32'(vm_if.coin_reject), 0);
    check("t4_credit200", 32'(vm_if.credit),      200);
    step(0, 0, 0, 0, 1, 0, 2'd0);
    for (int k = 0; k < 8; k++) begin
      idle();
      check("t4_chg25", 32'(vm_if.chg25), 1);
    end
    check("t4_drained", 32'(vm_if.credit), 0);
    check("t4_idle",    32'(vm_if.busy),   0);

    // Buy with a coin in the same cycle, then coins while busy
    step(0, 0, 1, 0, 0, 0, 2'd0);
    step(0, 0, 1, 0, 0, 0, 2'd0);
    step(0, 1, 0, 1, 0, 0, 2'd0);
    check("t5_reject_buy", 32'(vm_if.coin_reject), 1);
    check("t5_credit25",   32'(vm_if.credit),      25);
    step(1, 0, 0, 0, 0, 0, 2'd0);
    check("t5_dispense",    32'(vm_if.dispense),    1);
    check("t5_disp_id",     32'(vm_if.disp_id),     0);
    check("t5_reject_vend", 32'(vm_if.coin_reject), 1);
    step(0, 1, 0, 0, 0, 0, 2'd0);
    check("t5_chg25",      32'(vm_if.chg25),       1);
    check("t5_reject_chg", 32'(vm_if.coin_reject), 1);
    check("t5_credit0",    32'(vm_if.credit),      0);
    idle();
    check("t5_quiet", 32'({vm_if.chg25, vm_if.coin_reject, vm_if.busy}), 0);

    // Reset mid change train abandons remaining coins and restores stock
    step(0, 0, 1, 0, 0, 0, 2'd0);
    step(0, 0, 1, 0, 0, 0, 2'd0);
    step(0, 0, 1, 0, 0, 0, 2'd0);
    step(0, 1, 0, 0, 0, 0, 2'd0);
    step(0, 1, 0, 0, 0, 0, 2'd0);
    check("t6_credit95", 32'(vm_if.credit), 95);
    step(0, 0, 0, 0, 1, 0, 2'd0);
    idle();
    check("t6_chg25",   32'(vm_if.chg25),  1);
    check("t6_credit70", 32'(vm_if.credit), 70);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    check("t6_rst_chg",    32'({vm_if.chg25, vm_if.chg10, vm_if.chg5}), 0);
    check("t6_rst_credit", 32'(vm_if.credit), 0);
    check("t6_rst_busy",   32'(vm_if.busy),   0);
    idle();
    idle();
    check("t6_no_more_chg", 32'({vm_if.chg25, vm_if.chg10, vm_if.chg5}), 0);
    // Stock of product 0 is back to 4: four buys dispense before sold-out
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 0, 0, 0, 2'd0);
      step(0, 0, 0, 1, 0, 0, 2'd0);
      check("t6_stock_deny", 32'(vm_if.deny), 0);
      idle();
    end
    check("t6_sold_out", 32'(vm_if.sold_out), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
